// File: rtl/alu_pkg.sv
// alu_pkg: ALU widths, control codes and flag bit positions shared by the ALU and its arbiter
package alu_pkg;
    localparam int ALU_W  = 32;
    localparam int CTRL_W = 4;
    localparam int FLAG_W = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef enum logic [CTRL_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ctrl_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, lowest requester at or above ptr first, then wrap
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt
);
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] req_hi;
    always_comb begin
        mask   = {NREQ{1'b1}} << ptr;
        req_hi = req & mask;
        gnt    = |req_hi ? req_hi & (~req_hi + 1'b1) : req & (~req + 1'b1);
    end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one ALU with a registered response; ALU_SHARE_ARB_PERF_EN adds grant_cnt
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int ID_W  = 1,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*ALU_W-1:0]  req_srcA,
    input  logic [NREQ*ALU_W-1:0]  req_srcB,
    input  logic [NREQ*CTRL_W-1:0] req_ctrl,
    output logic [ALU_W-1:0]       alu_srcA,
    output logic [ALU_W-1:0]       alu_srcB,
    output logic [CTRL_W-1:0]      alu_ctrl,
    input  logic [ALU_W-1:0]       alu_result,
    input  logic [FLAG_W-1:0]      alu_flags,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ALU_W-1:0]       rsp_result,
    output logic [FLAG_W-1:0]      rsp_flags,
`ifdef ALU_SHARE_ARB_PERF_EN
    output logic [NREQ*CNT_W-1:0]  grant_cnt,
`endif
    output logic [ID_W-1:0]        rsp_id
);
    logic [NREQ-1:0]   gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ALU_W-1:0]  rsp_result_q, rsp_result_d;
    logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
    logic              can_accept, accept;

    rr_arbiter #(.NREQ(NREQ), .PTR_W(ID_W)) u_arb (
        .req(req_valid),
        .ptr(rr_ptr_q),
        .gnt(gnt)
    );

    // AND-OR mux on the one-hot grant; zero grant drives ADD 0+0 into the ALU
    always_comb begin
        alu_srcA = '0;
        alu_srcB = '0;
        alu_ctrl = '0;
        gnt_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            alu_srcA = alu_srcA | (req_srcA[i*ALU_W +: ALU_W] & {ALU_W{gnt[i]}});
            alu_srcB = alu_srcB | (req_srcB[i*ALU_W +: ALU_W] & {ALU_W{gnt[i]}});
            alu_ctrl = alu_ctrl | (req_ctrl[i*CTRL_W +: CTRL_W] & {CTRL_W{gnt[i]}});
            gnt_idx  = gnt[i] ? ID_W'(i) : gnt_idx;
        end
        can_accept   = ~rsp_valid_q | rsp_ready;
        req_ready    = gnt & {NREQ{can_accept}};
        accept       = |(req_valid & req_ready);
        rsp_valid_d  = accept | (rsp_valid_q & ~rsp_ready);
        rsp_result_d = accept ? alu_result : rsp_result_q;
        rsp_flags_d  = accept ? alu_flags : rsp_flags_q;
        rsp_id_d     = accept ? gnt_idx : rsp_id_q;
        rr_ptr_d     = !accept ? rr_ptr_q : (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_id_q     <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_id     = rsp_id_q;

`ifdef ALU_SHARE_ARB_PERF_EN
    logic [NREQ*CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i*CNT_W +: CNT_W] = (req_valid[i] & req_ready[i] & ~&cnt_q[i*CNT_W +: CNT_W]) ?
                                      cnt_q[i*CNT_W +: CNT_W] + 1'b1 : cnt_q[i*CNT_W +: CNT_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: behavioural ALU, arbitration scoreboard, single-op vector table and corner sequences
module tb_alu_share_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_srcA = '0;
    logic [63:0] req_srcB = '0;
    logic [7:0]  req_ctrl = '0;
    logic [31:0] alu_srcA, alu_srcB, alu_result;
    logic [3:0]  alu_ctrl, alu_flags;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [0:0]  rsp_id;
`ifdef ALU_SHARE_ARB_PERF_EN
    logic [7:0]  grant_cnt;
`endif
    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  c;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        logic        id;
    } exp_t;

    vec_t tbl[12];
    exp_t sb[$];
    logic m_ptr = 1'b0;

    alu_share_arb #(.NREQ(2), .ID_W(1), .CNT_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_srcA(req_srcA),
        .req_srcB(req_srcB),
        .req_ctrl(req_ctrl),
        .alu_srcA(alu_srcA),
        .alu_srcB(alu_srcB),
        .alu_ctrl(alu_ctrl),
        .alu_result(alu_result),
        .alu_flags(alu_flags),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_flags(rsp_flags),
`ifdef ALU_SHARE_ARB_PERF_EN
        .grant_cnt(grant_cnt),
`endif
        .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    // Returns {N,Z,C,V, result}; C is carry-out (no-borrow on SUB), C/V are 0 for non-arithmetic ops
    function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic cy, v;
        cy = 1'b0;
        v  = 1'b0;
        s  = '0;
        case (c)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cy = s[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; cy = s[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = {31'b0, $signed(a) < $signed(b)};
            4'd5: r = a << b[4:0];
            4'd6: r = {31'b0, a < b};
            4'd7: r = a ^ b;
            4'd8: r = a >> b[4:0];
            4'd9: r = $signed(a) >>> b[4:0];
            default: r = '0;
        endcase
        return {r[31], r == 32'd0, cy, v, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_f(alu_srcA, alu_srcB, alu_ctrl);

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1, input logic rr);
        req_valid = v;
        req_srcA  = {a1, a0};
        req_srcB  = {b1, b0};
        req_ctrl  = {c1, c0};
        rsp_ready = rr;
    endtask

    // Cycle model: expected grant/ready from its own pointer, expected responses queued at accept
    always @(negedge clk) begin
        logic gi;
        logic [1:0] er;
        exp_t e;
        logic [35:0] fr;
        if (!rst_n) begin
            m_ptr = 1'b0;
            sb.delete();
        end else begin
            gi = req_valid[m_ptr] ? m_ptr : ~m_ptr;
            er = (|req_valid && (sb.size() == 0 || rsp_ready)) ? (gi ? 2'b10 : 2'b01) : 2'b00;
            chk("sb_req_ready", {34'b0, req_ready}, {34'b0, er});
            chk("sb_rsp_valid", {35'b0, rsp_valid}, {35'b0, sb.size() != 0});
            if (sb.size() != 0) begin
                chk("sb_result", {4'b0, rsp_result}, {4'b0, sb[0].r});
                chk("sb_flags", {32'b0, rsp_flags}, {32'b0, sb[0].f});
                chk("sb_id", {35'b0, rsp_id}, {35'b0, sb[0].id});
                if (rsp_ready) void'(sb.pop_front());
            end
            if (|er) begin
                fr = gi ? alu_f(req_srcA[63:32], req_srcB[63:32], req_ctrl[7:4])
                        : alu_f(req_srcA[31:0], req_srcB[31:0], req_ctrl[3:0]);
                e.r  = fr[31:0];
                e.f  = fr[35:32];
                e.id = gi;
                sb.push_back(e);
                m_ptr = ~gi;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 32'd5,          32'd7,          4'd0,  32'd12,         4'b0000};
        tbl[1]  = '{1'b0, 32'd3,          32'd3,          4'd1,  32'd0,          4'b0110};
        tbl[2]  = '{1'b1, 32'h0000_F0F0,  32'h0000_0FF0,  4'd2,  32'h0000_00F0,  4'b0000};
        tbl[3]  = '{1'b1, 32'd0,          32'd0,          4'd3,  32'd0,          4'b0100};
        tbl[4]  = '{1'b0, 32'd1,          32'd2,          4'd1,  32'hFFFF_FFFF,  4'b1000};
        tbl[5]  = '{1'b0, 32'h7FFF_FFFF,  32'd1,          4'd0,  32'h8000_0000,  4'b1001};
        tbl[6]  = '{1'b1, 32'hFFFF_FFFF,  32'd1,          4'd0,  32'd0,          4'b0110};
        tbl[7]  = '{1'b0, 32'd2,          32'hFFFF_FFFF,  4'd4,  32'd0,          4'b0100};
        tbl[8]  = '{1'b1, 32'h0000_00FF,  32'h0000_000F,  4'd7,  32'h0000_00F0,  4'b0000};
        tbl[9]  = '{1'b0, 32'd9,          32'd9,          4'd15, 32'd0,          4'b0100};
        tbl[10] = '{1'b1, 32'd1,          32'd4,          4'd5,  32'd16,         4'b0000};
        tbl[11] = '{1'b0, 32'h8000_0000,  32'd4,          4'd9,  32'hF800_0000,  4'b1000};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {35'b0, rsp_valid}, 36'd0);
        chk("rst_result", {4'b0, rsp_result}, 36'd0);
        chk("rst_flags", {32'b0, rsp_flags}, 36'd0);
        chk("rst_id", {35'b0, rsp_id}, 36'd0);
        chk("rst_ready", {34'b0, req_ready}, 36'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (tbl[i].id) drive(2'b10, ~tbl[i].a, ~tbl[i].b, 4'd7, tbl[i].a, tbl[i].b, tbl[i].c, 1'b1);
            else           drive(2'b01, tbl[i].a, tbl[i].b, tbl[i].c, ~tbl[i].a, ~tbl[i].b, 4'd7, 1'b1);
            #1;
            chk("vec_ready", {34'b0, req_ready}, tbl[i].id ? 36'd2 : 36'd1);
            @(posedge clk);
            #1;
            drive(2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
            chk("vec_valid", {35'b0, rsp_valid}, 36'd1);
            chk("vec_result", {4'b0, rsp_result}, {4'b0, tbl[i].r});
            chk("vec_flags", {32'b0, rsp_flags}, {32'b0, tbl[i].f});
            chk("vec_id", {35'b0, rsp_id}, {35'b0, tbl[i].id});
        end

        // Last table op was requester 0, so the pointer now favours requester 1
        @(posedge clk);
        #1;
        drive(2'b11, 32'd10, 32'd1, 4'd0, 32'd20, 32'd2, 4'd0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("alt_valid", {35'b0, rsp_valid}, 36'd1);
            chk("alt_id", {35'b0, rsp_id}, (k % 2 == 0) ? 36'd1 : 36'd0);
            chk("alt_result", {4'b0, rsp_result}, (k % 2 == 0) ? 36'd22 : 36'd11);
        end

        drive(2'b10, 32'd10, 32'd1, 4'd0, 32'd100, 32'd1, 4'd1, 1'b0);
        #1;
        chk("hold_ready0", {34'b0, req_ready}, 36'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("hold_ready", {34'b0, req_ready}, 36'd0);
            chk("hold_valid", {35'b0, rsp_valid}, 36'd1);
            chk("hold_result", {4'b0, rsp_result}, 36'd11);
            chk("hold_flags", {32'b0, rsp_flags}, 36'd0);
            chk("hold_id", {35'b0, rsp_id}, 36'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("drain_accept_ready", {34'b0, req_ready}, 36'd2);
        @(posedge clk);
        #1;
        chk("drain_id", {35'b0, rsp_id}, 36'd1);
        chk("drain_result", {4'b0, rsp_result}, 36'd99);
        chk("drain_flags", {32'b0, rsp_flags}, 36'b0010);

        drive(2'b01, 32'd1, 32'd1, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
        @(posedge clk);
        #1;
        chk("pre_rst_id", {35'b0, rsp_id}, 36'd0);
        chk("pre_rst_result", {4'b0, rsp_result}, 36'd2);
        drive(2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {35'b0, rsp_valid}, 36'd0);
        chk("arst_result", {4'b0, rsp_result}, 36'd0);
        chk("arst_flags", {32'b0, rsp_flags}, 36'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(2'b11, 32'd10, 32'd1, 4'd0, 32'd20, 32'd2, 4'd0, 1'b1);
        #1;
        chk("post_rst_gnt", {34'b0, req_ready}, 36'd1);
        @(posedge clk);
        #1;
        chk("post_rst_id", {35'b0, rsp_id}, 36'd0);
        chk("post_rst_result", {4'b0, rsp_result}, 36'd11);
        drive(2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);

`ifdef ALU_SHARE_ARB_PERF_EN
        @(posedge clk);
        #1;
        drive(2'b01, 32'd4, 32'd4, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("cnt0_mid", {28'b0, grant_cnt}, 36'h0B);
        repeat (10) @(posedge clk);
        #1;
        chk("cnt0_sat", {32'b0, grant_cnt[3:0]}, 36'd15);
        chk("cnt1_zero", {32'b0, grant_cnt[7:4]}, 36'd0);
        drive(2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 36'(sb.size()), 36'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
